// File: rtl/ped_request_arbiter_pkg.sv
// Shared types and constants for the pedestrian request arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [1:0] {
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVE,
        HOLDOFF
    } arb_state_t;

    localparam int N_DIR_DEFAULT = 4;

    // Cycle constants derived from the 50 MHz system clock.
    localparam int CLK_HZ                 = 50_000_000;
    localparam int HOLDOFF_CYCLES_DEFAULT = 5 * CLK_HZ;    // 5 s gap after a service
    localparam int SERVE_TIMEOUT_DEFAULT  = 30 * CLK_HZ;   // 30 s before declaring a fault

    // Bits needed to hold 0..max_count; never less than one bit so a zero
    // parameter still yields a legal counter.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(longint'(max_count) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ped_request_arbiter_rr_select.sv
// Round-robin picker: first set bit of pending, searching from rr_ptr and wrapping.
// Latency: purely combinational.
// Backpressure: none; ports are pending/rr_ptr in, any/selected out.
module rr_select #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         pending,
    input  logic [$clog2(N_DIR)-1:0] rr_ptr,
    output logic                     any,
    output logic [$clog2(N_DIR)-1:0] selected
);

    localparam int DW = $clog2(N_DIR);

    always_comb begin
        logic [DW-1:0] cand;
        any      = 1'b0;
        selected = '0;
        cand     = '0;
        // Walk from the farthest candidate back towards rr_ptr so that the
        // nearest pending direction is written last and wins.
        for (int k = N_DIR - 1; k >= 0; k--) begin
            cand = DW'((int'(rr_ptr) + k) % N_DIR);
            if (pending[cand]) begin
                any      = 1'b1;
                selected = cand;
            end
        end
    end

endmodule

// File: rtl/ped_request_arbiter.sv
// Latches pedestrian button presses per direction and grants them one at a time, round-robin.
// Latency: press -> pending 1 cycle, pending -> grant_valid 1 cycle; serve_done -> next grant HOLDOFF_CYCLES+2.
// Backpressure: grant_dir/grant_valid hold until grant_ready; new presses keep latching meanwhile.
// Ports: clk/rst (async, active-high), btn_level in, grant_valid/grant_dir/grant_ready handshake,
//        serve_done pulse in, pending/busy/fault status out.
module ped_request_arbiter
    import traffic_pkg::*;
#(
    parameter int N_DIR          = N_DIR_DEFAULT,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT,
    parameter int SERVE_TIMEOUT  = SERVE_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DIR-1:0]         btn_level,
    output logic                     grant_valid,
    output logic [$clog2(N_DIR)-1:0] grant_dir,
    input  logic                     grant_ready,
    input  logic                     serve_done,
    output logic [N_DIR-1:0]         pending,
    output logic                     busy,
    output logic                     fault
);

    localparam int DW = $clog2(N_DIR);
    localparam int SW = cnt_width(SERVE_TIMEOUT);
    localparam int HW = cnt_width(HOLDOFF_CYCLES);

    arb_state_t       state;
    logic [N_DIR-1:0] btn_prev;
    logic [N_DIR-1:0] rise;
    logic [N_DIR-1:0] grant_mask;
    logic [DW-1:0]    rr_ptr;
    logic [DW-1:0]    sel_dir;
    logic             sel_any;
    logic             handshake;
    logic [SW-1:0]    serve_cnt;
    logic [HW-1:0]    hold_cnt;

    assign rise       = btn_level & ~btn_prev;
    assign handshake  = grant_valid & grant_ready;
    assign grant_mask = handshake ? (N_DIR'(1) << grant_dir) : '0;
    assign busy       = (state != IDLE);

    // btn_prev resets to all-ones so a button held through reset must be
    // released and pressed again before it counts. Clear beats set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= '1;
            pending  <= '0;
        end else begin
            btn_prev <= btn_level;
            pending  <= (pending | rise) & ~grant_mask;
        end
    end

    rr_select #(
        .N_DIR(N_DIR)
    ) u_rr_select (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .any     (sel_any),
        .selected(sel_dir)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_dir   <= '0;
            rr_ptr      <= '0;
            serve_cnt   <= '0;
            hold_cnt    <= '0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state       <= OFFER;
                        grant_valid <= 1'b1;
                        grant_dir   <= sel_dir;
                    end
                end
                // grant_dir stays frozen here; later presses only affect pending.
                OFFER: begin
                    if (handshake) begin
                        state       <= SERVE;
                        grant_valid <= 1'b0;
                        serve_cnt   <= '0;
                        rr_ptr      <= (grant_dir == DW'(N_DIR - 1)) ? '0 : grant_dir + 1'b1;
                    end
                end
                SERVE: begin
                    if (serve_done) begin
                        state     <= HOLDOFF;
                        serve_cnt <= '0;
                        hold_cnt  <= '0;
                    end else if (int'(serve_cnt) >= SERVE_TIMEOUT - 1) begin
                        // This edge is the SERVE_TIMEOUT-th cycle since the handshake.
                        fault     <= 1'b1;
                        state     <= HOLDOFF;
                        serve_cnt <= '0;
                        hold_cnt  <= '0;
                    end else if (serve_cnt != '1) begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                // Exits after HOLDOFF_CYCLES+1 cycles, so a zero gap still costs one cycle.
                HOLDOFF: begin
                    if (int'(hold_cnt) >= HOLDOFF_CYCLES) begin
                        state <= IDLE;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
